// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: requester-side and AXI read-channel signals of the read arbiter
interface axi_read_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req;
    logic [32*NUM_PORTS-1:0] req_addr;
    logic [NUM_PORTS-1:0]    req_burst;
    logic [NUM_PORTS-1:0]    req_ack;
    logic [31:0]             rsp_data;
    logic [NUM_PORTS-1:0]    rsp_valid;
    logic                    rsp_last;
    logic                    rsp_err;
    logic [3:0]              axim_arid;
    logic [31:0]             axim_araddr;
    logic [3:0]              axim_arlen;
    logic [2:0]              axim_arsize;
    logic [1:0]              axim_arburst;
    logic                    axim_arvalid;
    logic                    axim_arready;
    logic [3:0]              axim_rid;
    logic [31:0]             axim_rdata;
    logic [1:0]              axim_rresp;
    logic                    axim_rlast;
    logic                    axim_rvalid;
    logic                    axim_rready;
    modport master (
        input  req, req_addr, req_burst,
        output req_ack, rsp_data, rsp_valid, rsp_last, rsp_err,
        output axim_arid, axim_araddr, axim_arlen, axim_arsize, axim_arburst, axim_arvalid,
        input  axim_arready,
        input  axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_rvalid,
        output axim_rready
    );
    modport slave (
        output req, req_addr, req_burst,
        input  req_ack, rsp_data, rsp_valid, rsp_last, rsp_err,
        input  axim_arid, axim_araddr, axim_arlen, axim_arsize, axim_arburst, axim_arvalid,
        output axim_arready,
        output axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_rvalid,
        input  axim_rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter funnelling per-port word/line reads onto one AXI read channel
module axi_read_arbiter #(
    parameter int         NUM_PORTS  = 2,
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] ID_BASE    = 4'd0
) (
    input logic                clk,
    input logic                rst,
    axi_read_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t      state;
    logic [1:0]  last, idx, gnt, p;
    logic [2:0]  s;
    logic [3:0]  req4, burst4, cnt;
    logic [31:0] sel_addr;
    logic        beat, at_len, fin, bad, err_acc;
    assign bus.axim_arsize = 3'b010;
    assign beat   = bus.axim_rvalid && bus.axim_rready;
    assign at_len = cnt == bus.axim_arlen;
    assign fin    = bus.axim_rlast || at_len;
    assign bad    = bus.axim_rresp != 2'b00 || bus.axim_rid != bus.axim_arid || bus.axim_rlast != at_len;
    // pick the first requesting port after the last grant; scanning downward leaves the nearest one
    always_comb begin
        req4   = 4'(bus.req);
        burst4 = 4'(bus.req_burst);
        gnt    = last;
        s      = '0;
        p      = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            s = {1'b0, last} + 3'(i);
            p = s >= 3'(NUM_PORTS) ? 2'(s - 3'(NUM_PORTS)) : s[1:0];
            if (req4[p]) gnt = p;
        end
        sel_addr = 32'(bus.req_addr >> {gnt, 5'd0});
    end
    // transaction FSM: grant in IDLE, address phase in AR, beat forwarding and error tracking in R
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last             <= 2'(NUM_PORTS - 1);
            idx              <= '0;
            cnt              <= '0;
            err_acc          <= 1'b0;
            bus.req_ack      <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_valid    <= '0;
            bus.rsp_last     <= 1'b0;
            bus.rsp_err      <= 1'b0;
            bus.axim_arid    <= '0;
            bus.axim_araddr  <= '0;
            bus.axim_arlen   <= '0;
            bus.axim_arburst <= 2'b01;
            bus.axim_arvalid <= 1'b0;
            bus.axim_rready  <= 1'b0;
        end else begin
            bus.req_ack   <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_last  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                IDLE: if (|bus.req) begin
                    state            <= AR;
                    last             <= gnt;
                    idx              <= gnt;
                    bus.req_ack      <= NUM_PORTS'(1) << gnt;
                    bus.axim_araddr  <= sel_addr & ~32'd3;
                    bus.axim_arlen   <= burst4[gnt] ? 4'(LINE_WORDS - 1) : 4'd0;
                    bus.axim_arburst <= burst4[gnt] ? 2'b10 : 2'b01;
                    bus.axim_arid    <= ID_BASE + {2'b00, gnt};
                    bus.axim_arvalid <= 1'b1;
                end
                AR: if (bus.axim_arready) begin
                    state            <= R;
                    bus.axim_arvalid <= 1'b0;
                    bus.axim_rready  <= 1'b1;
                    cnt              <= '0;
                    err_acc          <= 1'b0;
                end
                R: if (beat) begin
                    bus.rsp_data  <= bus.axim_rdata;
                    bus.rsp_valid <= NUM_PORTS'(1) << idx;
                    if (fin) begin
                        bus.rsp_last    <= 1'b1;
                        bus.rsp_err     <= err_acc | bad;
                        bus.axim_rready <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt     <= cnt + 4'd1;
                        err_acc <= err_acc | bad;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: scoreboard bench driving requesters and an AXI read slave model
module tb_axi_read_arbiter;
    localparam int         NP  = 2;
    localparam int         LW  = 8;
    localparam logic [3:0] IDB = 4'd0;
    typedef struct {
        logic [NP-1:0] v;
        logic [31:0]   d;
        logic          last;
        logic          err;
    } beat_t;
    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    beat_t mon_exp;
    axi_read_arbiter_if #(.NUM_PORTS(NP)) bus();
    axi_read_arbiter #(.NUM_PORTS(NP), .LINE_WORDS(LW), .ID_BASE(IDB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // response scoreboard: every delivered beat must match the oldest expected one
    always @(negedge clk) begin
        if (bus.rsp_valid != '0) begin
            if (q.size() == 0) check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            else begin
                mon_exp = q.pop_front();
                check("rsp_valid", 32'(bus.rsp_valid), 32'(mon_exp.v));
                check("rsp_data", bus.rsp_data, mon_exp.d);
                check("rsp_last", 32'(bus.rsp_last), 32'(mon_exp.last));
                if (mon_exp.last) check("rsp_err", 32'(bus.rsp_err), 32'(mon_exp.err));
            end
        end else if (bus.rsp_last) check("orphan_last", 32'(bus.rsp_last), 32'd0);
    end
    task automatic wait_ack(int port);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ack != '0) break;
        end
        check("req_ack", 32'(bus.req_ack), 32'(NP'(1) << port));
    endtask
    task automatic drive_beat(int port, int b, int rl, int eb);
        bus.axim_rvalid = 1'b1;
        bus.axim_rdata  = {8'hA5, 8'(port), 16'(b)};
        bus.axim_rid    = IDB + 4'(port);
        bus.axim_rresp  = (b == eb) ? 2'b10 : 2'b00;
        bus.axim_rlast  = (b == rl);
    endtask
    task automatic txn(int port, bit hold, int ar_dly, int nb, int rl, int eb);
        logic [31:0] a   = bus.req_addr[32*port +: 32];
        logic        bst = bus.req_burst[port];
        logic [3:0]  len = bst ? 4'(LW - 1) : 4'd0;
        logic        err = 1'b0;
        logic        fin;
        beat_t       e;
        bus.req[port] = 1'b1;
        wait_ack(port);
        if (!hold) bus.req = '0;
        check("araddr", bus.axim_araddr, {a[31:2], 2'b00});
        check("arlen", 32'(bus.axim_arlen), 32'(len));
        check("arburst", 32'(bus.axim_arburst), bst ? 32'd2 : 32'd1);
        check("arid", 32'(bus.axim_arid), 32'(IDB + 4'(port)));
        check("arvalid", 32'(bus.axim_arvalid), 32'd1);
        repeat (ar_dly) begin
            @(posedge clk); #1;
            check("araddr_hold", bus.axim_araddr, {a[31:2], 2'b00});
            check("arvalid_hold", 32'(bus.axim_arvalid), 32'd1);
        end
        bus.axim_arready = 1'b1;
        @(posedge clk); #1;
        bus.axim_arready = 1'b0;
        check("ack_pulse", 32'(bus.req_ack), 32'd0);
        check("arvalid_off", 32'(bus.axim_arvalid), 32'd0);
        check("rready_on", 32'(bus.axim_rready), 32'd1);
        for (int b = 0; b < nb; b++) begin
            drive_beat(port, b, rl, eb);
            fin = (b == rl) || (b == int'(len));
            err = err | (b == eb) | ((b == rl) != (b == int'(len)));
            e.v = NP'(1) << port;
            e.d = bus.axim_rdata;
            e.last = fin;
            e.err = fin & err;
            q.push_back(e);
            @(posedge clk); #1;
            if (fin) break;
        end
        bus.axim_rvalid = 1'b0;
        bus.axim_rlast  = 1'b0;
        bus.axim_rresp  = 2'b00;
        @(negedge clk); #1;
        check("drain", 32'(q.size()), 32'd0);
        check("no_grant_with_last", 32'(bus.req_ack), 32'd0);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        e_init();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ack", 32'(bus.req_ack), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_arvalid", 32'(bus.axim_arvalid), 32'd0);
        check("rst_rready", 32'(bus.axim_rready), 32'd0);
        check("rst_arburst", 32'(bus.axim_arburst), 32'd1);
        check("rst_arsize", 32'(bus.axim_arsize), 32'd2);
        check("rst_araddr", bus.axim_araddr, 32'd0);
        check("rst_arlen", 32'(bus.axim_arlen), 32'd0);
        check("rst_arid", 32'(bus.axim_arid), 32'd0);
        rst = 1'b0;
        bus.req_addr[31:0] = 32'h1FC0_0004;
        bus.req_burst[0] = 1'b0;
        txn(0, 1'b0, 0, 1, 0, -1);
        bus.req_addr[63:32] = 32'h0000_1014;
        bus.req_burst[1] = 1'b1;
        txn(1, 1'b0, 0, 8, 7, -1);
        bus.req_addr = {32'h0000_0204, 32'h0000_0102};
        bus.req_burst = '0;
        bus.req = 2'b11;
        txn(0, 1'b1, 0, 1, 0, -1);
        txn(1, 1'b1, 0, 1, 0, -1);
        txn(0, 1'b0, 0, 1, 0, -1);
        bus.req_addr[63:32] = 32'h0000_3000;
        bus.req_burst[1] = 1'b1;
        txn(1, 1'b0, 5, 8, 7, 2);
        bus.req_addr[31:0] = 32'h0000_4010;
        bus.req_burst[0] = 1'b1;
        txn(0, 1'b0, 0, 8, 5, -1);
        bus.req_addr[31:0] = 32'h0000_2008;
        bus.req[0] = 1'b1;
        wait_ack(0);
        bus.req = '0;
        bus.axim_arready = 1'b1;
        @(posedge clk); #1;
        bus.axim_arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            drive_beat(0, b, 7, -1);
            q.push_back('{v: 2'b01, d: bus.axim_rdata, last: 1'b0, err: 1'b0});
            @(posedge clk); #1;
        end
        drive_beat(0, 3, 7, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_last", 32'(bus.rsp_last), 32'd0);
        check("mid_rst_rready", 32'(bus.axim_rready), 32'd0);
        check("mid_rst_arvalid", 32'(bus.axim_arvalid), 32'd0);
        check("mid_rst_araddr", bus.axim_araddr, 32'd0);
        check("mid_rst_arlen", 32'(bus.axim_arlen), 32'd0);
        for (int b = 4; b < 8; b++) begin
            drive_beat(0, b, 7, -1);
            @(posedge clk); #1;
            check("stray_rready", 32'(bus.axim_rready), 32'd0);
        end
        bus.axim_rvalid = 1'b0;
        bus.axim_rlast  = 1'b0;
        @(posedge clk); #1;
        check("rst_drain", 32'(q.size()), 32'd0);
        bus.req_addr[31:0] = 32'h0000_5006;
        bus.req_burst[0] = 1'b0;
        txn(0, 1'b0, 1, 1, 0, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    task automatic e_init();
        bus.req          = '0;
        bus.req_addr     = '0;
        bus.req_burst    = '0;
        bus.axim_arready = 1'b0;
        bus.axim_rid     = '0;
        bus.axim_rdata   = '0;
        bus.axim_rresp   = '0;
        bus.axim_rlast   = 1'b0;
        bus.axim_rvalid  = 1'b0;
    endtask
endmodule
